serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell (two half adders + OR)
// stepped LSB-first across a WIDTH-bit operand pair, one bit per clock.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic w_s1, w_c1, w_s, w_c2, w_carry_nxt;

  half_adder u_ha_ab (
    .i_a (r_op_a[0]),
    .i_b (r_op_b[0]),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha_cin (
    .i_a (w_s1),
    .i_b (r_carry),
    .o_s (w_s),
    .o_c (w_c2)
  );

  assign w_carry_nxt = w_c1 | w_c2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_carry <= w_carry_nxt;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          if (r_cnt == LAST_BIT) begin
            // r_carry here is the carry into the MSB.
            r_cout  <= w_carry_nxt;
            r_ovf   <= r_carry ^ w_carry_nxt;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances,
// hand-computed results, latency, handshake, ignored starts and async reset.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       ready2, busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .sub   (sub2),
    .a     (a2),
    .b     (b2),
    .ready (ready2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2),
    .ovf   (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 8-bit engine; returns the edge count at which done
  // was first seen (-1 if never) plus the results, then steps back to IDLE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        output int lat, output logic [7:0] rs, output logic rc,
                        output logic ro);
    lat = -1;
    rs  = '0;
    rc  = 1'b0;
    ro  = 1'b0;
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~ta; b8 = ~tb; sub8 = ~ts;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k; rs = sum8; rc = cout8; ro = ovf8;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  int         lat, d1, d2;
  logic [7:0] rs, s1, s2;
  logic       rc, ro, c1, o1, c2, o2, rdy9, rdy10;

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    #2;
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_done",  32'(done8),  32'd0);
    check("rst_sum",   32'(sum8),   32'd0);
    check("rst_cout",  32'(cout8),  32'd0);
    check("rst_ovf",   32'(ovf8),   32'd0);
    check("rst_ready_w2", 32'(ready2), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // 0x5A + 0x33 = 0x8D, signed overflow
    run_op(8'h5A, 8'h33, 1'b0, lat, rs, rc, ro);
    check("add1_lat",  32'(lat), 32'd8);
    check("add1_sum",  32'(rs),  32'h8D);
    check("add1_cout", 32'(rc),  32'd0);
    check("add1_ovf",  32'(ro),  32'd1);
    check("add1_idle_ready", 32'(ready8), 32'd1);
    check("add1_idle_done",  32'(done8),  32'd0);

    // Back to back with start held: 0xFF+0x01 then 0x7F+0x01 accepted at E10
    d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 0; o1 = 0; c2 = 0; o2 = 0;
    rdy9 = 1'b0; rdy10 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h7F; b8 = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (d1 < 0) begin
          d1 = k; s1 = sum8; c1 = cout8; o1 = ovf8;
        end else if (d2 < 0) begin
          d2 = k; s2 = sum8; c2 = cout8; o2 = ovf8;
        end
      end
      if (k == 9)  rdy9 = ready8;
      if (k == 10) begin
        rdy10 = ready8;
        start8 = 1'b0;
      end
    end
    check("b2b_first_lat",  32'(d1), 32'd8);
    check("b2b_first_sum",  32'(s1), 32'h00);
    check("b2b_first_cout", 32'(c1), 32'd1);
    check("b2b_first_ovf",  32'(o1), 32'd0);
    check("b2b_ready_e9",   32'(rdy9),  32'd1);
    check("b2b_ready_e10",  32'(rdy10), 32'd0);
    check("b2b_second_edge", 32'(d2), 32'd18);
    check("b2b_second_sum",  32'(s2), 32'h80);
    check("b2b_second_cout", 32'(c2), 32'd0);
    check("b2b_second_ovf",  32'(o2), 32'd1);

    // 0x10 - 0x20 = 0xF0 with borrow
    run_op(8'h10, 8'h20, 1'b1, lat, rs, rc, ro);
    check("sub1_lat",  32'(lat), 32'd8);
    check("sub1_sum",  32'(rs),  32'hF0);
    check("sub1_cout", 32'(rc),  32'd0);
    check("sub1_ovf",  32'(ro),  32'd0);

    // 0x80 - 0x01 = 0x7F, no borrow, signed overflow
    run_op(8'h80, 8'h01, 1'b1, lat, rs, rc, ro);
    check("sub2_sum",  32'(rs), 32'h7F);
    check("sub2_cout", 32'(rc), 32'd1);
    check("sub2_ovf",  32'(ro), 32'd1);

    // Async reset between edges while bit 4 is pending
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready8), 32'd1);
    check("arst_busy",  32'(busy8),  32'd0);
    check("arst_done",  32'(done8),  32'd0);
    check("arst_sum",   32'(sum8),   32'd0);
    check("arst_cout",  32'(cout8),  32'd0);
    check("arst_ovf",   32'(ovf8),   32'd0);
    #1 rst = 1'b0;

    run_op(8'h03, 8'h04, 1'b0, lat, rs, rc, ro);
    check("post_rst_lat",  32'(lat), 32'd8);
    check("post_rst_sum",  32'(rs),  32'h07);
    check("post_rst_cout", 32'(rc),  32'd0);
    check("post_rst_ovf",  32'(ro),  32'd0);

    // Starts pulsed during RUN and during DONE must be ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start8 = (k == 3 || k == 6 || k == 9);
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
      @(posedge clk); #1;
      if (k == 4) begin
        check("ign_run_ready", 32'(ready8), 32'd0);
        check("ign_run_busy",  32'(busy8),  32'd1);
      end
      if (k == 8) begin
        check("ign_done",     32'(done8), 32'd1);
        check("ign_done_sum", 32'(sum8),  32'h46);
      end
    end
    start8 = 1'b0;
    check("ign_idle_ready", 32'(ready8), 32'd1);
    @(posedge clk); #1;
    check("ign_after_busy", 32'(busy8), 32'd0);
    check("ign_after_sum",  32'(sum8),  32'h46);

    // WIDTH=2 instance: 3 + 1 wraps to 0 with carry, no overflow
    lat = -1; rs = '0; rc = 1'b0; ro = 1'b0;
    @(negedge clk);
    a2 = 2'b11; b2 = 2'b01; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = k; rs = 8'(sum2); rc = cout2; ro = ovf2;
        break;
      end
    end
    check("w2_lat",  32'(lat), 32'd2);
    check("w2_sum",  32'(rs),  32'd0);
    check("w2_cout", 32'(rc),  32'd1);
    check("w2_ovf",  32'(ro),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
